// File: rtl/pcie_us_dma_wr_desc_split.sv
// Write-descriptor splitter in front of the UltraScale PCIe write DMA engine.
// Cuts host writes at SEG_LEN boundaries and folds chunk statuses back into one.
module pcie_us_dma_wr_desc_split #(
   parameter int PCIE_ADDR_WIDTH = 64,
   parameter int AXI_ADDR_WIDTH  = 64,
   parameter int LEN_WIDTH       = 20,
   parameter int TAG_WIDTH       = 8,
   parameter int SEG_LEN         = 4096,
   parameter int DESC_TABLE_SIZE = 4,
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [PCIE_ADDR_WIDTH-1:0] s_axis_write_desc_pcie_addr,
   input  logic [AXI_ADDR_WIDTH-1:0]  s_axis_write_desc_axi_addr,
   input  logic [LEN_WIDTH-1:0]       s_axis_write_desc_len,
   input  logic [TAG_WIDTH-1:0]       s_axis_write_desc_tag,
   input  logic                       s_axis_write_desc_valid,
   output logic                       s_axis_write_desc_ready,
   output logic [PCIE_ADDR_WIDTH-1:0] m_axis_write_desc_pcie_addr,
   output logic [AXI_ADDR_WIDTH-1:0]  m_axis_write_desc_axi_addr,
   output logic [LEN_WIDTH-1:0]       m_axis_write_desc_len,
   output logic [TAG_WIDTH-1:0]       m_axis_write_desc_tag,
   output logic                       m_axis_write_desc_valid,
   input  logic                       m_axis_write_desc_ready,
   input  logic [TAG_WIDTH-1:0]       s_axis_write_desc_status_tag,
   input  logic                       s_axis_write_desc_status_valid,
   output logic [TAG_WIDTH-1:0]       m_axis_write_desc_status_tag,
   output logic                       m_axis_write_desc_status_valid,
   input  logic                       enable
);

   localparam int IDX_W = (DESC_TABLE_SIZE > 1) ? $clog2(DESC_TABLE_SIZE) : 1;
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int SEG_B = $clog2(SEG_LEN);

   typedef enum logic {
      S_IDLE,
      S_ISSUE
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [PCIE_ADDR_WIDTH-1:0] r_pcie_addr;
   logic [AXI_ADDR_WIDTH-1:0]  r_axi_addr;
   logic [LEN_WIDTH-1:0]       r_rem;
   logic [IDX_W-1:0]           r_idx;
   logic                       r_m_valid;
   logic [OUT_W-1:0]           r_out;
   logic [OUT_W-1:0]           w_out_next;

   logic [DESC_TABLE_SIZE-1:0] r_busy;
   logic [DESC_TABLE_SIZE-1:0] r_done;
   logic [TAG_WIDTH-1:0]       r_tag [DESC_TABLE_SIZE];
   logic [OUT_W-1:0]           r_cnt [DESC_TABLE_SIZE];
   logic [OUT_W-1:0]           w_cnt_next [DESC_TABLE_SIZE];
   logic [DESC_TABLE_SIZE-1:0] w_done_next;

   logic                       r_st_valid;
   logic [TAG_WIDTH-1:0]       r_st_tag;

   logic [LEN_WIDTH-1:0]       w_space;
   logic [LEN_WIDTH-1:0]       w_chunk_len;
   logic                       w_last;
   logic                       w_free_any;
   logic [IDX_W-1:0]           w_free_idx;
   logic                       w_s_ready;
   logic                       w_alloc;
   logic                       w_issue;
   logic                       w_issue_last;
   logic [IDX_W-1:0]           w_st_idx;
   logic                       w_st_ok;
   logic                       w_complete;
   logic                       w_unused_tag;

   // Chunk never crosses the next SEG_LEN-aligned host address.
   always_comb begin
      w_space = LEN_WIDTH'(SEG_LEN)
              - LEN_WIDTH'(r_pcie_addr[SEG_B-1:0]);
      w_chunk_len = (r_rem < w_space) ? r_rem : w_space;
      w_last = (r_rem == w_chunk_len);
   end

   always_comb begin
      w_free_any = 1'b0;
      w_free_idx = '0;
      for (int i = DESC_TABLE_SIZE - 1; i >= 0; i--) begin
         if (!r_busy[i]) begin
            w_free_any = 1'b1;
            w_free_idx = IDX_W'(i);
         end
      end
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM: next state
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_alloc) begin
               w_state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (w_issue_last) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // FSM: outputs and handshakes
   always_comb begin
      w_s_ready = (r_state == S_IDLE) && enable && w_free_any;
      w_alloc = w_s_ready && s_axis_write_desc_valid;
      w_issue = (r_state == S_ISSUE) && r_m_valid
              && m_axis_write_desc_ready;
      w_issue_last = w_issue && w_last;
   end

   assign w_st_idx = s_axis_write_desc_status_tag[IDX_W-1:0];
   assign w_unused_tag = ^s_axis_write_desc_status_tag;

   // Stray statuses (free entry or nothing in flight) are dropped.
   assign w_st_ok = s_axis_write_desc_status_valid
                  && r_busy[w_st_idx]
                  && (r_cnt[w_st_idx] != '0);

   always_comb begin
      for (int i = 0; i < DESC_TABLE_SIZE; i++) begin
         w_cnt_next[i] = r_cnt[i];
         w_done_next[i] = r_done[i];
         if (w_issue && (r_idx == IDX_W'(i))) begin
            if (!(w_st_ok && (w_st_idx == IDX_W'(i)))) begin
               w_cnt_next[i] = r_cnt[i] + 1'b1;
            end
            if (w_last) begin
               w_done_next[i] = 1'b1;
            end
         end else if (w_st_ok && (w_st_idx == IDX_W'(i))) begin
            w_cnt_next[i] = r_cnt[i] - 1'b1;
         end
      end
   end

   // Only the status-addressed entry can reach zero this cycle.
   assign w_complete = w_st_ok
                     && w_done_next[w_st_idx]
                     && (w_cnt_next[w_st_idx] == '0);

   always_comb begin
      w_out_next = r_out;
      if (w_issue && !w_st_ok) begin
         w_out_next = r_out + 1'b1;
      end else if (w_st_ok && !w_issue) begin
         w_out_next = r_out - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pcie_addr <= '0;
         r_axi_addr <= '0;
         r_rem <= '0;
         r_idx <= '0;
         r_m_valid <= 1'b0;
         r_out <= '0;
      end else begin
         if (w_alloc) begin
            r_pcie_addr <= s_axis_write_desc_pcie_addr;
            r_axi_addr <= s_axis_write_desc_axi_addr;
            r_rem <= s_axis_write_desc_len;
            r_idx <= w_free_idx;
         end else if (w_issue) begin
            r_pcie_addr <= r_pcie_addr
                         + PCIE_ADDR_WIDTH'(w_chunk_len);
            r_axi_addr <= r_axi_addr
                        + AXI_ADDR_WIDTH'(w_chunk_len);
            r_rem <= r_rem - w_chunk_len;
         end
         r_m_valid <= (w_state_next == S_ISSUE)
                   && (w_out_next < OUT_W'(MAX_OUTSTANDING));
         r_out <= w_out_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
         r_done <= '0;
         for (int i = 0; i < DESC_TABLE_SIZE; i++) begin
            r_tag[i] <= '0;
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DESC_TABLE_SIZE; i++) begin
            if (w_alloc && (w_free_idx == IDX_W'(i))) begin
               r_busy[i] <= 1'b1;
               r_done[i] <= 1'b0;
               r_tag[i] <= s_axis_write_desc_tag;
               r_cnt[i] <= '0;
            end else if (w_complete && (w_st_idx == IDX_W'(i))) begin
               r_busy[i] <= 1'b0;
               r_done[i] <= 1'b0;
               r_cnt[i] <= '0;
            end else begin
               r_done[i] <= w_done_next[i];
               r_cnt[i] <= w_cnt_next[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_st_valid <= 1'b0;
         r_st_tag <= '0;
      end else begin
         r_st_valid <= w_complete;
         r_st_tag <= w_complete ? r_tag[w_st_idx] : '0;
      end
   end

   assign s_axis_write_desc_ready = w_s_ready;
   assign m_axis_write_desc_pcie_addr = r_pcie_addr;
   assign m_axis_write_desc_axi_addr = r_axi_addr;
   assign m_axis_write_desc_len = w_chunk_len;
   assign m_axis_write_desc_tag = TAG_WIDTH'(r_idx);
   assign m_axis_write_desc_valid = r_m_valid;
   assign m_axis_write_desc_status_tag = r_st_tag;
   assign m_axis_write_desc_status_valid = r_st_valid;

endmodule

// File: tb/tb_pcie_us_dma_wr_desc_split.sv
// Directed bench for the write-descriptor splitter.
// Expected chunks and statuses are worked out by hand per step.
module tb_pcie_us_dma_wr_desc_split;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [63:0] s_pcie = '0;
   logic [63:0] s_axi = '0;
   logic [19:0] s_len = '0;
   logic [7:0]  s_tag = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [63:0] m_pcie;
   logic [63:0] m_axi;
   logic [19:0] m_len;
   logic [7:0]  m_tag;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [7:0]  es_tag = '0;
   logic        es_valid = 1'b0;
   logic [7:0]  st_tag;
   logic        st_valid;
   logic        enable = 1'b0;

   int checks = 0;
   int errors = 0;

   pcie_us_dma_wr_desc_split dut (
      .clk(clk),
      .rst_n(rst_n),
      .s_axis_write_desc_pcie_addr(s_pcie),
      .s_axis_write_desc_axi_addr(s_axi),
      .s_axis_write_desc_len(s_len),
      .s_axis_write_desc_tag(s_tag),
      .s_axis_write_desc_valid(s_valid),
      .s_axis_write_desc_ready(s_ready),
      .m_axis_write_desc_pcie_addr(m_pcie),
      .m_axis_write_desc_axi_addr(m_axi),
      .m_axis_write_desc_len(m_len),
      .m_axis_write_desc_tag(m_tag),
      .m_axis_write_desc_valid(m_valid),
      .m_axis_write_desc_ready(m_ready),
      .s_axis_write_desc_status_tag(es_tag),
      .s_axis_write_desc_status_valid(es_valid),
      .m_axis_write_desc_status_tag(st_tag),
      .m_axis_write_desc_status_valid(st_valid),
      .enable(enable)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic wait_mvalid(input string name);
      int n = 0;
      while (m_valid !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      check({name, " m_valid"}, 64'(m_valid), 64'd1);
   endtask

   task automatic check_fields(input string name,
                               input logic [63:0] pa,
                               input logic [63:0] aa,
                               input logic [63:0] ln,
                               input logic [63:0] tg);
      check({name, " pcie"}, m_pcie, pa);
      check({name, " axi"}, m_axi, aa);
      check({name, " len"}, 64'(m_len), ln);
      check({name, " tag"}, 64'(m_tag), tg);
   endtask

   task automatic expect_chunk(input string name,
                               input logic [63:0] pa,
                               input logic [63:0] aa,
                               input logic [63:0] ln,
                               input logic [63:0] tg);
      wait_mvalid(name);
      check_fields(name, pa, aa, ln, tg);
      step();
   endtask

   task automatic send_desc(input logic [63:0] pa,
                            input logic [63:0] aa,
                            input logic [19:0] ln,
                            input logic [7:0] tg);
      int n = 0;
      s_pcie = pa;
      s_axi = aa;
      s_len = ln;
      s_tag = tg;
      s_valid = 1'b1;
      while (s_ready !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      check("desc accept", 64'(s_ready), 64'd1);
      step();
      s_valid = 1'b0;
   endtask

   task automatic send_status(input logic [7:0] tg);
      es_tag = tg;
      es_valid = 1'b1;
      step();
      es_valid = 1'b0;
   endtask

   task automatic check_status(input string name,
                               input logic v,
                               input logic [7:0] tg);
      check({name, " st_valid"}, 64'(st_valid), 64'(v));
      if (v) begin
         check({name, " st_tag"}, 64'(st_tag), 64'(tg));
      end
   endtask

   initial begin
      #2 rst_n = 1'b0;
      step();
      step();
      check("rst m_valid", 64'(m_valid), 64'd0);
      check("rst st_valid", 64'(st_valid), 64'd0);
      check("rst s_ready", 64'(s_ready), 64'd0);
      check_fields("rst", 64'h0, 64'h0, 64'h0, 64'h0);
      enable = 1'b1;
      #1;
      check("enable s_ready", 64'(s_ready), 64'd1);
      step();
      rst_n = 1'b1;
      step();

      // single chunk, status one cycle after engine status
      send_desc(64'h1000, 64'h0, 20'd256, 8'h5A);
      expect_chunk("A", 64'h1000, 64'h0, 64'd256, 64'd0);
      send_status(8'h00);
      check_status("A done", 1'b1, 8'h5A);
      step();
      check_status("A single", 1'b0, 8'h00);

      // unaligned 10000-byte write splits into four chunks
      send_desc(64'h0FF0, 64'h8000, 20'd10000, 8'h33);
      expect_chunk("B0", 64'h0FF0, 64'h8000, 64'd16, 64'd0);
      expect_chunk("B1", 64'h1000, 64'h8010, 64'd4096, 64'd0);
      expect_chunk("B2", 64'h2000, 64'h9010, 64'd4096, 64'd0);
      expect_chunk("B3", 64'h3000, 64'hA010, 64'd1792, 64'd0);
      check("B issued", 64'(m_valid), 64'd0);
      for (int k = 0; k < 4; k++) begin
         send_status(8'h00);
         check_status("B status", k == 3, 8'h33);
      end
      step();
      check_status("B single", 1'b0, 8'h00);

      // stall stability, then outstanding limit of 16
      m_ready = 1'b0;
      send_desc(64'h100000, 64'h0, 20'd81920, 8'h77);
      wait_mvalid("C stall");
      for (int k = 0; k < 5; k++) begin
         step();
         check("C stall valid", 64'(m_valid), 64'd1);
         check_fields("C stall", 64'h100000, 64'h0, 64'd4096, 64'd0);
      end
      m_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         check("C burst valid", 64'(m_valid), 64'd1);
         check("C burst pcie", m_pcie, 64'h100000 + 64'(k) * 64'h1000);
         check("C burst axi", m_axi, 64'(k) * 64'h1000);
         step();
      end
      check("C limit valid", 64'(m_valid), 64'd0);
      step();
      step();
      check("C limit hold", 64'(m_valid), 64'd0);
      send_status(8'h00);
      check("C resume valid", 64'(m_valid), 64'd1);
      check("C resume pcie", m_pcie, 64'h110000);
      check_status("C early", 1'b0, 8'h00);
      for (int k = 1; k < 20; k++) begin
         send_status(8'h00);
         check_status("C status", k == 19, 8'h77);
      end

      // fill all four table entries
      send_desc(64'h0, 64'h0, 20'd16, 8'hA0);
      expect_chunk("D0", 64'h0, 64'h0, 64'd16, 64'd0);
      send_desc(64'h100, 64'h10, 20'd16, 8'hA1);
      expect_chunk("D1", 64'h100, 64'h10, 64'd16, 64'd1);
      send_desc(64'h200, 64'h20, 20'd16, 8'hA2);
      expect_chunk("D2", 64'h200, 64'h20, 64'd16, 64'd2);
      send_desc(64'h300, 64'h30, 20'd16, 8'hA3);
      expect_chunk("D3", 64'h300, 64'h30, 64'd16, 64'd3);
      check("full s_ready", 64'(s_ready), 64'd0);
      step();
      check("full hold", 64'(s_ready), 64'd0);
      send_status(8'h02);
      check_status("D2 first", 1'b1, 8'hA2);
      check("freed s_ready", 64'(s_ready), 64'd1);
      send_desc(64'h2000, 64'h200, 20'd32, 8'hE0);
      expect_chunk("E", 64'h2000, 64'h200, 64'd32, 64'd2);
      send_status(8'h00);
      check_status("D0", 1'b1, 8'hA0);
      send_status(8'h01);
      check_status("D1", 1'b1, 8'hA1);
      send_status(8'h03);
      check_status("D3", 1'b1, 8'hA3);
      send_status(8'h02);
      check_status("E", 1'b1, 8'hE0);

      // final chunk of G issued in the same cycle F's status returns
      send_desc(64'h5000, 64'h500, 20'd64, 8'hF0);
      expect_chunk("F", 64'h5000, 64'h500, 64'd64, 64'd0);
      send_desc(64'h6000, 64'h600, 20'd8, 8'hF1);
      wait_mvalid("G");
      check_fields("G", 64'h6000, 64'h600, 64'd8, 64'd1);
      send_status(8'h00);
      check_status("F same", 1'b1, 8'hF0);
      check("G issued", 64'(m_valid), 64'd0);
      step();
      check_status("G pending", 1'b0, 8'h00);
      send_status(8'h01);
      check_status("G done", 1'b1, 8'hF1);
      send_status(8'h01);
      check_status("stray busyfree", 1'b0, 8'h00);
      send_status(8'h03);
      check_status("stray free", 1'b0, 8'h00);

      // reset during ISSUE with entries 0 and 1 in use
      send_desc(64'h7000, 64'h0, 20'd4, 8'h99);
      expect_chunk("P", 64'h7000, 64'h0, 64'd4, 64'd0);
      m_ready = 1'b0;
      send_desc(64'h0, 64'h0, 20'd20000, 8'h11);
      wait_mvalid("H");
      check_fields("H", 64'h0, 64'h0, 64'd4096, 64'd1);
      rst_n = 1'b0;
      #1;
      check("midrst m_valid", 64'(m_valid), 64'd0);
      check("midrst st_valid", 64'(st_valid), 64'd0);
      check_fields("midrst", 64'h0, 64'h0, 64'h0, 64'h0);
      step();
      rst_n = 1'b1;
      m_ready = 1'b1;
      step();
      send_desc(64'h40, 64'h4, 20'd4, 8'h22);
      expect_chunk("I", 64'h40, 64'h4, 64'd4, 64'd0);
      send_status(8'h01);
      check_status("cleared entry", 1'b0, 8'h00);
      send_status(8'h00);
      check_status("I done", 1'b1, 8'h22);
      step();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
